pong_game_engine: RTL and testbench



---
 rtl/pong_game_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_engine.sv
// Pong game engine for a COLS x ROWS field: serve timing, ball kinematics,
// paddle collision, scoring and match-end detection, advanced by a tick strobe.
module pong_game_engine #(
    parameter int COLS        = 16,
    parameter int ROWS        = 16,
    parameter int XW          = 4,
    parameter int YW          = 4,
    parameter int SW          = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 500,
    parameter int BALL_DIV    = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            start,
    input  logic [4:0]      entropy,
    input  logic [ROWS-1:0] lpaddle,
    input  logic [ROWS-1:0] rpaddle,
    output logic [XW-1:0]   ball_x,
    output logic [YW-1:0]   ball_y,
    output logic [SW-1:0]   score_p1,
    output logic [SW-1:0]   score_p2,
    output logic            point_p1,
    output logic            point_p2,
    output logic            game_over,
    output logic            winner,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    // Vertical direction: 00 = still, 01 = down (+1), 11 = up (-1)
    localparam logic [1:0] DY_ZERO = 2'b00;
    localparam logic [1:0] DY_POS  = 2'b01;
    localparam logic [1:0] DY_NEG  = 2'b11;

    localparam int SCW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam int BDW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;

    localparam logic [XW-1:0]  X_CTR      = XW'(COLS / 2);
    localparam logic [YW-1:0]  Y_CTR      = YW'(ROWS / 2);
    localparam logic [XW-1:0]  X_LHIT     = XW'(1);
    localparam logic [XW-1:0]  X_LBACK    = XW'(2);
    localparam logic [XW-1:0]  X_RHIT     = XW'(COLS - 2);
    localparam logic [XW-1:0]  X_RBACK    = XW'(COLS - 3);
    localparam logic [XW-1:0]  X_RGOAL    = XW'(COLS - 1);
    localparam logic [YW-1:0]  Y_MAX      = YW'(ROWS - 1);
    localparam logic [SW-1:0]  WIN        = SW'(WIN_SCORE);
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_TICKS - 1);
    localparam logic [BDW-1:0] STEP_LAST  = BDW'(BALL_DIV - 1);

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           dx_q, dx_d;   // 1 = moving right
    logic [1:0]     dy_q, dy_d;
    logic [SW-1:0]  s1_q, s1_d;
    logic [SW-1:0]  s2_q, s2_d;
    logic           p1_q, p1_d;
    logic           p2_q, p2_d;
    logic           go_q, go_d;
    logic           win_q, win_d;
    logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
    logic [BDW-1:0] step_cnt_q, step_cnt_d;

    logic [YW-1:0]  ny;
    logic [1:0]     ndy;
    logic [SW-1:0]  new_score;
    logic           unused_entropy;

    assign unused_entropy = ^entropy[4:3];

    function automatic logic [1:0] dy_from(input logic [1:0] e);
        case (e)
            2'd0:    dy_from = DY_NEG;
            2'd2:    dy_from = DY_POS;
            default: dy_from = DY_ZERO;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        p1_d        = 1'b0;
        p2_d        = 1'b0;
        go_d        = go_q;
        win_d       = win_q;
        serve_cnt_d = serve_cnt_q;
        step_cnt_d  = step_cnt_q;
        ny          = y_q;
        ndy         = dy_q;
        new_score   = p1_q ? s1_q + SW'(1) : s2_q + SW'(1);

        case (state_q)
            IDLE: begin
                x_d = X_CTR;
                y_d = Y_CTR;
                if (start) begin
                    state_d     = SERVE;
                    serve_cnt_d = '0;
                    dx_d        = entropy[0];
                end
            end

            SERVE: begin
                if (tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d    = PLAY;
                        step_cnt_d = '0;
                        dy_d       = dy_from(entropy[2:1]);
                    end else begin
                        serve_cnt_d = serve_cnt_q + SCW'(1);
                    end
                end
            end

            PLAY: begin
                if (tick) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = '0;
                        // Wall bounce reflects within the same step
                        if (dy_q == DY_POS) begin
                            if (y_q == Y_MAX) begin
                                ny  = y_q - YW'(1);
                                ndy = DY_NEG;
                            end else begin
                                ny = y_q + YW'(1);
                            end
                        end else if (dy_q == DY_NEG) begin
                            if (y_q == '0) begin
                                ny  = y_q + YW'(1);
                                ndy = DY_POS;
                            end else begin
                                ny = y_q - YW'(1);
                            end
                        end
                        y_d  = ny;
                        dy_d = ndy;

                        if (!dx_q && x_q == X_LHIT) begin
                            if (lpaddle[ny]) begin
                                dx_d = 1'b1;
                                x_d  = X_LBACK;
                                dy_d = dy_from(entropy[2:1]);
                            end else begin
                                x_d     = '0;
                                p2_d    = 1'b1;
                                state_d = POINT;
                            end
                        end else if (dx_q && x_q == X_RHIT) begin
                            if (rpaddle[ny]) begin
                                dx_d = 1'b0;
                                x_d  = X_RBACK;
                                dy_d = dy_from(entropy[2:1]);
                            end else begin
                                x_d     = X_RGOAL;
                                p1_d    = 1'b1;
                                state_d = POINT;
                            end
                        end else begin
                            x_d = dx_q ? x_q + XW'(1) : x_q - XW'(1);
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + BDW'(1);
                    end
                end
            end

            POINT: begin
                if (p1_q) s1_d = new_score;
                else      s2_d = new_score;
                if (new_score == WIN) begin
                    state_d = GAMEOVER;
                    go_d    = 1'b1;
                    win_d   = ~p1_q;
                end else begin
                    // Next serve heads toward the player who just conceded
                    state_d     = SERVE;
                    serve_cnt_d = '0;
                    x_d         = X_CTR;
                    y_d         = Y_CTR;
                    dx_d        = p1_q;
                end
            end

            GAMEOVER: begin
                if (start) begin
                    state_d     = SERVE;
                    serve_cnt_d = '0;
                    dx_d        = entropy[0];
                    s1_d        = '0;
                    s2_d        = '0;
                    go_d        = 1'b0;
                    x_d         = X_CTR;
                    y_d         = Y_CTR;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= X_CTR;
            y_q         <= Y_CTR;
            dx_q        <= 1'b1;
            dy_q        <= DY_ZERO;
            s1_q        <= '0;
            s2_q        <= '0;
            p1_q        <= 1'b0;
            p2_q        <= 1'b0;
            go_q        <= 1'b0;
            win_q       <= 1'b0;
            serve_cnt_q <= '0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            go_q        <= go_d;
            win_q       <= win_d;
            serve_cnt_q <= serve_cnt_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score_p1  = s1_q;
    assign score_p2  = s2_q;
    assign point_p1  = p1_q;
    assign point_p2  = p2_q;
    assign game_over = go_q;
    assign winner    = win_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: directed game scenarios plus random play, checked
// every clock against an integer-arithmetic model of the game rules.
module tb_pong_game_engine;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int WIN_SCORE = 3;
    localparam int SERVE_TICKS = 2;
    localparam int BALL_DIV = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  entropy = '0;
    logic [15:0] lpaddle = '0;
    logic [15:0] rpaddle = '0;
    logic [3:0]  ball_x, ball_y, score_p1, score_p2;
    logic        point_p1, point_p2, game_over, winner;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    pong_game_engine #(
        .COLS(COLS), .ROWS(ROWS), .XW(4), .YW(4), .SW(4),
        .WIN_SCORE(WIN_SCORE), .SERVE_TICKS(SERVE_TICKS), .BALL_DIV(BALL_DIV)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .entropy(entropy),
        .lpaddle(lpaddle), .rpaddle(rpaddle),
        .ball_x(ball_x), .ball_y(ball_y), .score_p1(score_p1), .score_p2(score_p2),
        .point_p1(point_p1), .point_p2(point_p2), .game_over(game_over),
        .winner(winner), .state_o(state_o)
    );

    // ---------------- reference model (rules in plain integers) ----------------
    int m_state, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_sc, m_bc;
    bit m_p1, m_p2, m_go, m_win;

    function automatic int dy_of(input logic [4:0] e);
        case (e[2:1])
            2'd0:    return -1;
            2'd2:    return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_clock(input bit rst, input bit st, input bit tk,
                               input logic [4:0] ent, input logic [15:0] lp,
                               input logic [15:0] rp);
        bit was_p1, was_p2;
        int nx, ny, sc;
        was_p1 = m_p1;
        was_p2 = m_p2;
        m_p1 = 0;
        m_p2 = 0;
        if (rst) begin
            m_state = 0; m_x = COLS / 2; m_y = ROWS / 2; m_dx = 1; m_dy = 0;
            m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0; m_sc = 0; m_bc = 0;
        end else begin
            case (m_state)
                0: begin
                    m_x = COLS / 2; m_y = ROWS / 2;
                    if (st) begin m_state = 1; m_sc = 0; m_dx = ent[0] ? 1 : -1; end
                end
                1: if (tk) begin
                    if (m_sc == SERVE_TICKS - 1) begin
                        m_state = 2; m_bc = 0; m_dy = dy_of(ent);
                    end else m_sc++;
                end
                2: if (tk) begin
                    if (m_bc == BALL_DIV - 1) begin
                        m_bc = 0;
                        ny = m_y + m_dy;
                        if (ny < 0 || ny > ROWS - 1) begin
                            m_dy = -m_dy;
                            ny = m_y + m_dy;
                        end
                        m_y = ny;
                        nx = m_x + m_dx;
                        if (nx == 0) begin
                            if (lp[ny]) begin m_dx = 1; nx = 2; m_dy = dy_of(ent); end
                            else begin m_p2 = 1; m_state = 3; end
                        end else if (nx == COLS - 1) begin
                            if (rp[ny]) begin m_dx = -1; nx = COLS - 3; m_dy = dy_of(ent); end
                            else begin m_p1 = 1; m_state = 3; end
                        end
                        m_x = nx;
                    end else m_bc++;
                end
                3: begin
                    if (was_p1) begin m_s1++; sc = m_s1; end
                    else        begin m_s2++; sc = m_s2; end
                    if (sc == WIN_SCORE) begin
                        m_state = 4; m_go = 1; m_win = was_p2;
                    end else begin
                        m_state = 1; m_sc = 0; m_x = COLS / 2; m_y = ROWS / 2;
                        m_dx = was_p1 ? 1 : -1;
                    end
                end
                4: if (st) begin
                    m_state = 1; m_sc = 0; m_dx = ent[0] ? 1 : -1;
                    m_s1 = 0; m_s2 = 0; m_go = 0; m_x = COLS / 2; m_y = ROWS / 2;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic logic [22:0] snapshot();
        return {3'(m_state), 4'(m_x), 4'(m_y), 4'(m_s1), 4'(m_s2), m_p1, m_p2, m_go, m_win};
    endfunction

    // ---------------- scoreboard ----------------
    logic [22:0] exp_q[$];
    int          tag_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [22:0] mon_exp, mon_act;
    int          mon_tag;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {state_o, ball_x, ball_y, score_p1, score_p2,
                       point_p1, point_p2, game_over, winner};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_errors++;
                $display("FAIL outputs t=%0t: got st=%0d x=%0d y=%0d s1=%0d s2=%0d p1=%0b p2=%0b go=%0b w=%0b, expected st=%0d x=%0d y=%0d s1=%0d s2=%0d p1=%0b p2=%0b go=%0b w=%0b",
                         $time, mon_act[22:20], mon_act[19:16], mon_act[15:12], mon_act[11:8],
                         mon_act[7:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                         mon_exp[22:20], mon_exp[19:16], mon_exp[15:12], mon_exp[11:8],
                         mon_exp[7:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
            case (mon_tag)
                1: begin
                    chk("idle_state", int'(state_o), 0);
                    chk("idle_x", int'(ball_x), 8);
                    chk("idle_y", int'(ball_y), 8);
                    chk("idle_game_over", int'(game_over), 0);
                end
                2: chk("serve_to_play", int'(state_o), 2);
                3: chk("first_step_x", int'(ball_x), 9);
                4: begin
                    chk("match_state", int'(state_o), 4);
                    chk("match_score_p1", int'(score_p1), 3);
                    chk("match_game_over", int'(game_over), 1);
                    chk("match_winner", int'(winner), 0);
                end
                5: begin
                    chk("restart_state", int'(state_o), 1);
                    chk("restart_score_p1", int'(score_p1), 0);
                    chk("restart_game_over", int'(game_over), 0);
                end
                6: begin
                    chk("midplay_reset_state", int'(state_o), 0);
                    chk("midplay_reset_xy", int'({ball_x, ball_y}), 8'h88);
                    chk("midplay_reset_scores", int'({score_p1, score_p2}), 0);
                    chk("midplay_reset_flags", int'({point_p1, point_p2, game_over, winner}), 0);
                end
                default: ;
            endcase
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit rst, input bit st, input bit tk, input logic [4:0] ent,
                         input logic [15:0] lp, input logic [15:0] rp, input int tag);
        @(negedge clk);
        reset = rst; start = st; tick = tk; entropy = ent; lpaddle = lp; rpaddle = rp;
        model_clock(rst, st, tk, ent, lp, rp);
        exp_q.push_back(snapshot());
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_paddle();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int budget;
        // Reset, then ticks without start stay in IDLE
        cycle(1, 0, 0, 5'd0, 16'h0, 16'h0, 0);
        cycle(1, 0, 0, 5'd0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 5'd0, 16'h0, 16'h0, (i == 9) ? 1 : 0);

        // Serve rightward with flat trajectory, first step lands on column 9
        cycle(0, 1, 0, 5'b00011, 16'h0, 16'h0, 0);
        cycle(0, 0, 1, 5'b00011, 16'h0, 16'h0, 0);
        cycle(0, 0, 1, 5'b00011, 16'h0, 16'h0, 2);
        cycle(0, 0, 1, 5'b00011, 16'h0, 16'h0, 3);

        // Rally with full paddles and random bounces
        for (int i = 0; i < 150; i++)
            cycle(0, 0, 1, 5'($urandom), 16'hFFFF, 16'hFFFF, 0);

        // Right side concedes until the match ends
        budget = 0;
        while (!game_over && budget < 400) begin
            cycle(0, 0, 1, 5'b00011, 16'hFFFF, 16'h0, 0);
            budget++;
        end
        cycle(0, 0, 0, 5'b00011, 16'hFFFF, 16'h0, 4);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 5'($urandom), 16'h0, 16'h0, 0);
        cycle(0, 1, 0, 5'b00000, 16'h0, 16'h0, 5);

        // Random play
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) != 0, 5'($urandom), rand_paddle(), rand_paddle(), 0);

        // Score a point, get back into PLAY, then reset with tick and start high
        cycle(1, 0, 0, 5'd0, 16'h0, 16'h0, 0);
        cycle(0, 1, 0, 5'b00011, 16'hFFFF, 16'h0, 0);
        budget = 0;
        while (score_p1 == 0 && budget < 200) begin
            cycle(0, 0, 1, 5'b00011, 16'hFFFF, 16'h0, 0);
            budget++;
        end
        cycle(0, 0, 1, 5'b00101, 16'hFFFF, 16'h0, 0);
        cycle(0, 0, 1, 5'b00101, 16'hFFFF, 16'h0, 2);
        cycle(0, 0, 1, 5'b00101, 16'hFFFF, 16'h0, 0);
        cycle(1, 1, 1, 5'b11111, 16'hFFFF, 16'hFFFF, 6);
        cycle(0, 0, 1, 5'd0, 16'h0, 16'h0, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
